// File: rtl/mlp_io_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_io_sequencer
//
// Sequential wrapper around a combinational printed-MLP classifier.
//
// Features arrive one per beat on a valid/ready stream and are packed into
// the classifier's flat input vector. Feature k sits at [k*FEAT_W +: FEAT_W],
// and the first beat of a frame is k=0. After a complete frame the vector is
// held for SETTLE_CYC cycles. The class index is then captured and offered on
// a valid/ready result stream. Assembly of the next frame can overlap the
// settle and result phases, up to (but not including) its final beat.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   feat_valid     feature beat valid
//   feat_ready     feature beat accepted when feat_valid && feat_ready
//   feat_data      feature value (FEAT_W bits)
//   feat_last      marks final beat of a frame
//   mlp_inp        flat classifier input, N_FEAT*FEAT_W bits
//   mlp_out        class index returned by the classifier (combinational)
//   cls_valid      result valid
//   cls_ready      result consumed when cls_valid && cls_ready
//   cls_data       captured class index
//   frame_err      one-cycle pulse: malformed frame discarded
//   busy           back stage not idle
// ---------------------------------------------------------------------------
module mlp_io_sequencer #(
  parameter int N_FEAT     = 4,
  parameter int FEAT_W     = 4,
  parameter int CLS_W      = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     feat_valid,
  output logic                     feat_ready,
  input  logic [FEAT_W-1:0]        feat_data,
  input  logic                     feat_last,
  output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
  input  logic [CLS_W-1:0]         mlp_out,
  output logic                     cls_valid,
  input  logic                     cls_ready,
  output logic [CLS_W-1:0]         cls_data,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_FEAT);
  localparam int CNT_W = $clog2(SETTLE_CYC) + 1;
  localparam int ASM_W = (N_FEAT - 1) * FEAT_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  logic [IDX_W-1:0] idx_q;
  logic [ASM_W-1:0] asm_q, asm_next;

  logic at_last;
  logic beat_acc;
  logic beat_push;
  logic beat_good;
  logic beat_bad;

  // Back-stage status comes straight from the state register, which keeps
  // feat_ready free of any combinational path from cls_ready.
  assign busy      = (state_q != ST_IDLE);
  assign cls_valid = (state_q == ST_RESULT);

  // The final beat of a frame has to wait for an idle back stage, because
  // accepting it overwrites mlp_inp. Earlier beats only touch the private
  // assembly buffer, so they flow at full rate.
  assign at_last    = (idx_q == LAST_IDX);
  assign feat_ready = !rst && !(at_last && busy);

  assign beat_acc  = feat_valid && feat_ready;
  assign beat_push = beat_acc && !at_last && !feat_last;
  assign beat_good = beat_acc &&  at_last &&  feat_last;
  assign beat_bad  = beat_acc && (at_last != feat_last);

  // Drop the incoming feature into the assembly slot selected by idx.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < N_FEAT - 1; k++) begin
      if (idx_q == IDX_W'(k)) begin
        asm_next[k*FEAT_W +: FEAT_W] = feat_data;
      end
    end
  end

  // Load side: beat index, assembly buffer, classifier input, error pulse.
  // A malformed frame only rewinds the index. Stale slots do no harm,
  // because every slot is rewritten before the next good final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      asm_q     <= '0;
      mlp_inp   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= beat_bad;
      if (beat_push) begin
        asm_q <= asm_next;
        idx_q <= idx_q + IDX_W'(1);
      end else if (beat_good || beat_bad) begin
        idx_q <= '0;
      end
      if (beat_good) begin
        mlp_inp <= {feat_data, asm_q};
      end
    end
  end

  // Back-stage state register, settle counter and class capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cls_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        cls_data <= mlp_out;
      end
    end
  end

  // Back-stage next state. The counter is loaded together with the good
  // final beat. Capture happens on the settle cycle in which it reads zero,
  // which gives exactly SETTLE_CYC settle cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (beat_good) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_INIT;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESULT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESULT: begin
        if (cls_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mlp_io_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mlp_io_sequencer
//
// Drives mlp_io_sequencer with feature frames and stands in for the
// classifier through a driven mlp_out. Expected class results are queued
// when a final beat is driven. They are popped by a monitor whenever a
// result handshake occurs. A second instance with SETTLE_CYC=1 covers the
// shortest settle time.
// ---------------------------------------------------------------------------
module tb_mlp_io_sequencer;

  logic        clk;
  logic        rst;

  logic        feat_valid;
  logic        feat_ready;
  logic [3:0]  feat_data;
  logic        feat_last;
  logic [15:0] mlp_inp;
  logic [1:0]  mlp_out;
  logic        cls_valid;
  logic        cls_ready;
  logic [1:0]  cls_data;
  logic        frame_err;
  logic        busy;

  logic        s_feat_valid;
  logic        s_feat_ready;
  logic [3:0]  s_feat_data;
  logic        s_feat_last;
  logic [15:0] s_mlp_inp;
  logic [1:0]  s_mlp_out;
  logic        s_cls_valid;
  logic        s_cls_ready;
  logic [1:0]  s_cls_data;
  logic        s_frame_err;
  logic        s_busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  sb_exp;

  mlp_io_sequencer #(
    .N_FEAT(4), .FEAT_W(4), .CLS_W(2), .SETTLE_CYC(3)
  ) dut (
    .clk(clk), .rst(rst),
    .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data), .feat_last(feat_last),
    .mlp_inp(mlp_inp), .mlp_out(mlp_out),
    .cls_valid(cls_valid), .cls_ready(cls_ready), .cls_data(cls_data),
    .frame_err(frame_err), .busy(busy)
  );

  mlp_io_sequencer #(
    .N_FEAT(4), .FEAT_W(4), .CLS_W(2), .SETTLE_CYC(1)
  ) dut_s1 (
    .clk(clk), .rst(rst),
    .feat_valid(s_feat_valid), .feat_ready(s_feat_ready),
    .feat_data(s_feat_data), .feat_last(s_feat_last),
    .mlp_inp(s_mlp_inp), .mlp_out(s_mlp_out),
    .cls_valid(s_cls_valid), .cls_ready(s_cls_ready), .cls_data(s_cls_data),
    .frame_err(s_frame_err), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result monitor. It samples mid low phase, after the stimulus for the
  // cycle has settled, and checks each handshake against the queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && cls_valid && cls_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL sb_unexpected: got cls_data=%b, required no result", cls_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (cls_data !== sb_exp) begin
            n_bad++;
            $display("[TB] FAIL sb_cls_data: got %b, required %b", cls_data, sb_exp);
          end
        end
      end
    end
  end

  // Watchdog in case a bounded wait is itself broken.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Present one beat at a negedge and hold it until accepted. Returns at the
  // negedge of the cycle after acceptance, with feat_valid dropped.
  task automatic send_beat(input logic [3:0] d, input logic l);
    int n;
    n = 0;
    feat_valid = 1'b1;
    feat_data  = d;
    feat_last  = l;
    while (!feat_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL beat_timeout: feat_ready=%b for 50 cycles, required 1", feat_ready);
    end
    @(negedge clk);
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL idle_timeout: busy=%b pending=%0d, required 0/0", busy, exp_q.size());
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!cls_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL result_timeout: cls_valid=%b, required 1", cls_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    feat_valid = 1'b0; feat_data = '0; feat_last = 1'b0;
    cls_ready = 1'b0; mlp_out = '0;
    s_feat_valid = 1'b0; s_feat_data = '0; s_feat_last = 1'b0;
    s_cls_ready = 1'b0; s_mlp_out = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mlp_inp, cls_valid, cls_data, frame_err, busy, feat_ready} !== 22'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_state: got inp=%h v=%b d=%b err=%b busy=%b rdy=%b, required all 0",
               mlp_inp, cls_valid, cls_data, frame_err, busy, feat_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (feat_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_release_ready: got %b, required 1", feat_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_nominal();
    cls_ready = 1'b1;
    mlp_out   = 2'b10;
    send_beat(4'h9, 1'b0);
    send_beat(4'h3, 1'b0);
    send_beat(4'hC, 1'b0);
    exp_q.push_back(2'b10);
    send_beat(4'h5, 1'b1);
    n_cmp++;
    if (mlp_inp !== 16'h5C39) begin
      n_bad++;
      $display("[TB] FAIL nominal_inp: got %h, required 5c39", mlp_inp);
    end
    for (int c = 1; c <= 5; c++) begin
      n_cmp++;
      if (busy !== (c <= 4)) begin
        n_bad++;
        $display("[TB] FAIL nominal_busy T+%0d: got %b, required %b", c, busy, (c <= 4));
      end
      n_cmp++;
      if (cls_valid !== (c == 4)) begin
        n_bad++;
        $display("[TB] FAIL nominal_valid T+%0d: got %b, required %b", c, cls_valid, (c == 4));
      end
      @(negedge clk);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    cls_ready = 1'b0;
    mlp_out   = 2'b11;
    send_beat(4'h6, 1'b0);
    send_beat(4'h7, 1'b0);
    send_beat(4'h8, 1'b0);
    exp_q.push_back(2'b11);
    send_beat(4'h9, 1'b1);
    wait_result();
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b0);
    send_beat(4'h3, 1'b0);
    feat_valid = 1'b1; feat_data = 4'h4; feat_last = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if ({feat_ready, cls_valid, cls_data, mlp_inp} !== {1'b0, 1'b1, 2'b11, 16'h9876}) begin
        n_bad++;
        $display("[TB] FAIL bp_hold %0d: got rdy=%b v=%b d=%b inp=%h, required 0 1 11 9876",
                 i, feat_ready, cls_valid, cls_data, mlp_inp);
      end
      @(negedge clk);
    end
    cls_ready = 1'b1;
    mlp_out   = 2'b01;
    exp_q.push_back(2'b01);
    n_cmp++;
    if (feat_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL bp_ready_H: got %b, required 0", feat_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({feat_ready, cls_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL bp_H1: got rdy=%b v=%b busy=%b, required 1 0 0", feat_ready, cls_valid, busy);
    end
    @(negedge clk);
    feat_valid = 1'b0; feat_last = 1'b0;
    n_cmp++;
    if ({mlp_inp, busy} !== {16'h4321, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL bp_H2: got inp=%h busy=%b, required 4321 1", mlp_inp, busy);
    end
    wait_idle();
  endtask

  task automatic test_early_last();
    cls_ready = 1'b1;
    send_beat(4'hA, 1'b0);
    send_beat(4'hB, 1'b1);
    n_cmp++;
    if ({frame_err, busy} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL early_err: got err=%b busy=%b, required 1 0", frame_err, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({frame_err, cls_valid, busy, mlp_inp} !== {3'b000, 16'h4321}) begin
        n_bad++;
        $display("[TB] FAIL early_after %0d: got err=%b v=%b busy=%b inp=%h, required 0 0 0 4321",
                 i, frame_err, cls_valid, busy, mlp_inp);
      end
    end
    mlp_out = 2'b00;
    send_beat(4'hF, 1'b0);
    send_beat(4'h0, 1'b0);
    send_beat(4'hF, 1'b0);
    exp_q.push_back(2'b00);
    send_beat(4'h0, 1'b1);
    n_cmp++;
    if (mlp_inp !== 16'h0F0F) begin
      n_bad++;
      $display("[TB] FAIL early_next_inp: got %h, required 0f0f", mlp_inp);
    end
    wait_idle();
  endtask

  task automatic test_missing_last();
    cls_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(4'h1, 1'b0);
    n_cmp++;
    if ({frame_err, busy, mlp_inp} !== {2'b10, 16'h0F0F}) begin
      n_bad++;
      $display("[TB] FAIL missing_err: got err=%b busy=%b inp=%h, required 1 0 0f0f", frame_err, busy, mlp_inp);
    end
    @(negedge clk);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL missing_pulse_len: got %b, required 0", frame_err);
    end
    mlp_out = 2'b11;
    send_beat(4'h2, 1'b0);
    send_beat(4'h4, 1'b0);
    send_beat(4'h6, 1'b0);
    exp_q.push_back(2'b11);
    send_beat(4'h8, 1'b1);
    n_cmp++;
    if ({mlp_inp, frame_err} !== {16'h8642, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL missing_next_inp: got inp=%h err=%b, required 8642 0", mlp_inp, frame_err);
    end
    wait_idle();
  endtask

  task automatic test_capture_instant();
    cls_ready = 1'b1;
    mlp_out   = 2'b00;
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b0);
    send_beat(4'h3, 1'b0);
    exp_q.push_back(2'b01);
    send_beat(4'h4, 1'b1);
    @(negedge clk);
    @(negedge clk);
    mlp_out = 2'b01;
    @(negedge clk);
    mlp_out = 2'b10;
    n_cmp++;
    if ({cls_valid, cls_data} !== 3'b101) begin
      n_bad++;
      $display("[TB] FAIL capture_T4: got v=%b d=%b, required 1 01", cls_valid, cls_data);
    end
    wait_idle();
  endtask

  task automatic test_settle_one();
    logic [3:0] beats [4];
    beats = '{4'h1, 4'h2, 4'h3, 4'h4};
    s_cls_ready = 1'b1;
    s_mlp_out   = 2'b00;
    for (int i = 0; i < 4; i++) begin
      s_feat_valid = 1'b1;
      s_feat_data  = beats[i];
      s_feat_last  = (i == 3);
      n_cmp++;
      if (s_feat_ready !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL s1_ready beat %0d: got %b, required 1", i, s_feat_ready);
      end
      @(negedge clk);
    end
    s_feat_valid = 1'b0; s_feat_last = 1'b0;
    s_mlp_out = 2'b11;
    n_cmp++;
    if ({s_mlp_inp, s_busy, s_cls_valid} !== {16'h4321, 2'b10}) begin
      n_bad++;
      $display("[TB] FAIL s1_T1: got inp=%h busy=%b v=%b, required 4321 1 0", s_mlp_inp, s_busy, s_cls_valid);
    end
    @(negedge clk);
    s_mlp_out = 2'b00;
    n_cmp++;
    if ({s_cls_valid, s_cls_data} !== 3'b111) begin
      n_bad++;
      $display("[TB] FAIL s1_T2: got v=%b d=%b, required 1 11", s_cls_valid, s_cls_data);
    end
    @(negedge clk);
    n_cmp++;
    if ({s_cls_valid, s_busy} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL s1_T3: got v=%b busy=%b, required 0 0", s_cls_valid, s_busy);
    end
  endtask

  task automatic test_reset_mid();
    cls_ready = 1'b0;
    mlp_out   = 2'b10;
    send_beat(4'h3, 1'b0);
    send_beat(4'h3, 1'b0);
    send_beat(4'h3, 1'b0);
    send_beat(4'h3, 1'b1);
    wait_result();
    send_beat(4'h7, 1'b0);
    send_beat(4'h7, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mlp_inp, cls_valid, cls_data, frame_err, busy, feat_ready} !== 22'd0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset_state: got inp=%h v=%b d=%b err=%b busy=%b rdy=%b, required all 0",
               mlp_inp, cls_valid, cls_data, frame_err, busy, feat_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({feat_ready, frame_err, cls_valid} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL mid_release: got rdy=%b err=%b v=%b, required 1 0 0", feat_ready, frame_err, cls_valid);
    end
    @(negedge clk);
    cls_ready = 1'b1;
    mlp_out   = 2'b01;
    send_beat(4'hD, 1'b0);
    send_beat(4'hE, 1'b0);
    send_beat(4'hA, 1'b0);
    exp_q.push_back(2'b01);
    send_beat(4'hD, 1'b1);
    n_cmp++;
    if ({mlp_inp, frame_err} !== {16'hDAED, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL mid_next_inp: got inp=%h err=%b, required daed 0", mlp_inp, frame_err);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_capture_instant();
    test_settle_one();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL sb_leftover: got %0d pending results, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
